// File: rtl/mem_port_arbiter_if.sv
// Bundle of fetch, LSU and memory-side signals for mem_port_arbiter.
// slave is the arbiter view; master is the surrounding environment view.
interface mem_port_arbiter_if;
    logic        instr_req_i;
    logic [31:0] instr_addr_i;
    logic        instr_gnt_o;
    logic        instr_rvalid_o;
    logic [31:0] instr_rdata_o;
    logic        instr_err_o;
    logic        data_req_i;
    logic        data_we_i;
    logic [3:0]  data_be_i;
    logic [31:0] data_addr_i;
    logic [31:0] data_wdata_i;
    logic        data_gnt_o;
    logic        data_rvalid_o;
    logic [31:0] data_rdata_o;
    logic        data_err_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic        mem_gnt_i;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;
    logic        mem_err_i;
    logic        protocol_err_o;

    modport slave (
        input  instr_req_i, instr_addr_i,
        input  data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
        input  mem_gnt_i, mem_rvalid_i, mem_rdata_i, mem_err_i,
        output instr_gnt_o, instr_rvalid_o, instr_rdata_o, instr_err_o,
        output data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o,
        output mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
        output protocol_err_o
    );

    modport master (
        output instr_req_i, instr_addr_i,
        output data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
        output mem_gnt_i, mem_rvalid_i, mem_rdata_i, mem_err_i,
        input  instr_gnt_o, instr_rvalid_o, instr_rdata_o, instr_err_o,
        input  data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o,
        input  mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
        input  protocol_err_o
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch and LSU, routing in-order responses.
// Define ARB_ROUND_ROBIN_EN for round-robin arbitration (default: data first).
module mem_port_arbiter #(
    parameter int MAX_OUTSTANDING = 2
) (
    input logic clk,
    input logic rst,
    mem_port_arbiter_if.slave bus
);
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);
    localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t state, state_nxt;
    logic lock_owner, lock_owner_nxt;
    logic owner, owner_req, mem_req, grant;
    logic prefer_data, fifo_full, pop, head;
    logic [MAX_OUTSTANDING-1:0] fifo_q;
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic protocol_err;

    function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
        return (p == PW'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
    endfunction

`ifdef ARB_ROUND_ROBIN_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) prefer_data <= 1'b1;
        else if (grant) prefer_data <= ~owner;
    end
`else
    assign prefer_data = 1'b1;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            lock_owner <= 1'b0;
        end else begin
            state      <= state_nxt;
            lock_owner <= lock_owner_nxt;
        end
    end

    // owner 1 = data, 0 = instr; LOCKED pins it until the address is taken
    always_comb begin
        state_nxt      = state;
        lock_owner_nxt = lock_owner;
        owner          = bus.data_req_i;
        if (state == LOCKED)
            owner = lock_owner;
        else if (bus.data_req_i && bus.instr_req_i)
            owner = prefer_data;
        owner_req = owner ? bus.data_req_i : bus.instr_req_i;
        mem_req   = owner_req & ~fifo_full;
        grant     = mem_req & bus.mem_gnt_i;
        case (state)
            IDLE: begin
                if (mem_req && !bus.mem_gnt_i) begin
                    state_nxt      = LOCKED;
                    lock_owner_nxt = owner;
                end
            end
            LOCKED: begin
                if (bus.mem_gnt_i) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign fifo_full = (count == CW'(MAX_OUTSTANDING));
    assign pop       = bus.mem_rvalid_i & (count != '0);
    assign head      = fifo_q[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fifo_q       <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            protocol_err <= 1'b0;
        end else begin
            if (grant) begin
                fifo_q[wr_ptr] <= owner;
                wr_ptr         <= wrap_inc(wr_ptr);
            end
            if (pop) rd_ptr <= wrap_inc(rd_ptr);
            case ({grant, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (bus.mem_rvalid_i && count == '0) protocol_err <= 1'b1;
        end
    end

    assign bus.mem_req_o   = mem_req;
    assign bus.mem_we_o    = owner & bus.data_we_i;
    assign bus.mem_be_o    = owner ? bus.data_be_i : 4'hF;
    assign bus.mem_addr_o  = owner ? bus.data_addr_i : bus.instr_addr_i;
    assign bus.mem_wdata_o = bus.data_wdata_i;

    assign bus.instr_gnt_o = grant & ~owner;
    assign bus.data_gnt_o  = grant & owner;

    assign bus.instr_rvalid_o = pop & ~head;
    assign bus.data_rvalid_o  = pop & head;
    assign bus.instr_rdata_o  = bus.instr_rvalid_o ? bus.mem_rdata_i : '0;
    assign bus.data_rdata_o   = bus.data_rvalid_o ? bus.mem_rdata_i : '0;
    assign bus.instr_err_o    = bus.instr_rvalid_o & bus.mem_err_i;
    assign bus.data_err_o     = bus.data_rvalid_o & bus.mem_err_i;

    assign bus.protocol_err_o = protocol_err;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed plus random bench for mem_port_arbiter against a queue-based
// model of ownership, locking and in-order response routing.
module tb_mem_port_arbiter;
    localparam int MAX = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_port_arbiter_if bus();

    mem_port_arbiter #(.MAX_OUTSTANDING(MAX)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int vectors = 0;
    int miscompares = 0;

    bit q[$];
    bit perr;
    bit pend_v, pend_o;
    bit pref_d;
    bit last_ig, last_dg;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_in();
        bus.instr_req_i  = 0;
        bus.instr_addr_i = 0;
        bus.data_req_i   = 0;
        bus.data_we_i    = 0;
        bus.data_be_i    = 0;
        bus.data_addr_i  = 0;
        bus.data_wdata_i = 0;
        bus.mem_gnt_i    = 0;
        bus.mem_rvalid_i = 0;
        bus.mem_rdata_i  = 0;
        bus.mem_err_i    = 0;
    endtask

    task automatic model_clear();
        q.delete();
        perr   = 0;
        pend_v = 0;
        pend_o = 0;
        pref_d = 1;
        last_ig = 0;
        last_dg = 0;
    endtask

    task automatic do_reset();
        idle_in();
        rst = 1;
        model_clear();
        @(negedge clk);
        chk("rst_mem_req", bus.mem_req_o, 0);
        chk("rst_gnt", {bus.instr_gnt_o, bus.data_gnt_o}, 0);
        chk("rst_rvalid", {bus.instr_rvalid_o, bus.data_rvalid_o}, 0);
        chk("rst_perr", bus.protocol_err_o, 0);
        @(posedge clk);
        #1 rst = 0;
    endtask

    // one cycle: predict from current inputs, check mid-cycle, advance model
    task automatic step();
        bit owner, oreq, mreq, g, pop, hd;
        if (pend_v)
            owner = pend_o;
        else if (bus.data_req_i && bus.instr_req_i)
`ifdef ARB_ROUND_ROBIN_EN
            owner = pref_d;
`else
            owner = 1'b1;
`endif
        else
            owner = bus.data_req_i;
        oreq = owner ? bus.data_req_i : bus.instr_req_i;
        mreq = oreq && (q.size() < MAX);
        g    = mreq && bus.mem_gnt_i;
        pop  = bus.mem_rvalid_i && (q.size() != 0);
        hd   = pop ? q[0] : 1'b0;
        @(negedge clk);
        chk("mem_req", bus.mem_req_o, mreq);
        chk("instr_gnt", bus.instr_gnt_o, g && !owner);
        chk("data_gnt", bus.data_gnt_o, g && owner);
        if (mreq) begin
            chk("mem_addr", bus.mem_addr_o,
                owner ? bus.data_addr_i : bus.instr_addr_i);
            chk("mem_we", bus.mem_we_o, owner && bus.data_we_i);
            chk("mem_be", bus.mem_be_o, owner ? bus.data_be_i : 4'hF);
            if (owner) chk("mem_wdata", bus.mem_wdata_o, bus.data_wdata_i);
        end
        chk("instr_rvalid", bus.instr_rvalid_o, pop && !hd);
        chk("data_rvalid", bus.data_rvalid_o, pop && hd);
        if (pop && !hd) begin
            chk("instr_rdata", bus.instr_rdata_o, bus.mem_rdata_i);
            chk("instr_err", bus.instr_err_o, bus.mem_err_i);
        end
        if (pop && hd) begin
            chk("data_rdata", bus.data_rdata_o, bus.mem_rdata_i);
            chk("data_err", bus.data_err_o, bus.mem_err_i);
        end
        chk("protocol_err", bus.protocol_err_o, perr);
        @(posedge clk);
        if (pop) void'(q.pop_front());
        else if (bus.mem_rvalid_i) perr = 1;
        if (g) begin
            q.push_back(owner);
            pref_d = !owner;
            pend_v = 0;
        end else if (mreq) begin
            pend_v = 1;
            pend_o = owner;
        end
        last_ig = g && !owner;
        last_dg = g && owner;
        #1;
    endtask

    task automatic drain();
        idle_in();
        for (int i = 0; i < 8 && q.size() != 0; i++) begin
            bus.mem_rvalid_i = 1;
            bus.mem_rdata_i  = $urandom;
            step();
        end
        idle_in();
    endtask

    initial begin
        rst = 1;
        idle_in();
        model_clear();
        @(posedge clk);
        #1;
        do_reset();
        step();

        // single fetch, response two cycles later
        bus.instr_req_i = 1; bus.instr_addr_i = 32'h100; bus.mem_gnt_i = 1;
        step();
        idle_in();
        step();
        bus.mem_rvalid_i = 1; bus.mem_rdata_i = 32'h0000_0013;
        step();
        idle_in();

        // contention with back-to-back grants and pops
        bus.instr_req_i = 1; bus.instr_addr_i = 32'h200;
        bus.data_req_i = 1; bus.data_addr_i = 32'h400;
        bus.data_be_i = 4'h3; bus.data_we_i = 1; bus.data_wdata_i = 32'hCAFE;
        bus.mem_gnt_i = 1;
        step();
        bus.mem_rvalid_i = 1;
        for (int i = 0; i < 6; i++) begin
            bus.mem_rdata_i = 32'h50 + i;
            step();
        end
        drain();

        // lock hold: instr stalls three cycles while data arrives
        bus.instr_req_i = 1; bus.instr_addr_i = 32'h300;
        step();
        bus.data_req_i = 1; bus.data_addr_i = 32'h800; bus.data_be_i = 4'hF;
        step();
        step();
        bus.mem_gnt_i = 1;
        step();
        bus.instr_req_i = 0;
        step();
        drain();

        // full FIFO, then one pop re-enables the request next cycle
        bus.data_req_i = 1; bus.data_addr_i = 32'h900; bus.data_be_i = 4'h1;
        bus.mem_gnt_i = 1;
        step();
        step();
        step();
        bus.mem_rvalid_i = 1; bus.mem_rdata_i = 32'h77;
        step();
        bus.mem_rvalid_i = 0;
        step();
        drain();

        // data read then instr; responses 0xA, 0xB
        bus.data_req_i = 1; bus.data_addr_i = 32'hA0; bus.mem_gnt_i = 1;
        step();
        bus.data_req_i = 0; bus.instr_req_i = 1; bus.instr_addr_i = 32'hB0;
        step();
        idle_in();
        bus.mem_rvalid_i = 1; bus.mem_rdata_i = 32'hA;
        step();
        bus.mem_rdata_i = 32'hB; bus.mem_err_i = 1;
        step();
        idle_in();

        // spurious response is dropped and the flag sticks
        bus.mem_rvalid_i = 1; bus.mem_rdata_i = 32'hDEAD;
        step();
        idle_in();
        step();
        step();

        // reset forgets in-flight work; its late response is unexpected
        do_reset();
        bus.data_req_i = 1; bus.data_addr_i = 32'hC0; bus.mem_gnt_i = 1;
        step();
        do_reset();
        bus.mem_rvalid_i = 1;
        step();
        idle_in();
        step();
        do_reset();

        // random traffic honouring hold-until-grant
        for (int n = 0; n < 400; n++) begin
            if (!(bus.instr_req_i && !last_ig)) begin
                bus.instr_req_i  = ($urandom_range(0, 2) != 0);
                bus.instr_addr_i = $urandom;
            end
            if (!(bus.data_req_i && !last_dg)) begin
                bus.data_req_i   = ($urandom_range(0, 2) != 0);
                bus.data_addr_i  = $urandom;
                bus.data_we_i    = $urandom_range(0, 1);
                bus.data_be_i    = $urandom_range(0, 15);
                bus.data_wdata_i = $urandom;
            end
            bus.mem_gnt_i    = ($urandom_range(0, 3) != 0);
            bus.mem_rvalid_i = (q.size() != 0) ? ($urandom_range(0, 2) != 0)
                                               : ($urandom_range(0, 30) == 0);
            bus.mem_rdata_i  = $urandom;
            bus.mem_err_i    = ($urandom_range(0, 7) == 0);
            step();
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single core memory port between the instruction-fetch requester and the load/store data requester. It uses the same req/gnt/rvalid handshake as the fetch stage's memory interface. The block sits between the fetch and memory stages and the external memory. It selects one address-phase request per cycle, tracks every granted transaction in an owner FIFO, and routes each in-order response back to the requester that issued it.

## Interface
- MAX_OUTSTANDING, 2: number of granted transactions still awaiting rvalid; legal range 1..4.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- instr_req_i  in  1  fetch request.
- instr_addr_i  in  32  fetch address.
- instr_gnt_o  out  1  fetch address phase accepted.
- instr_rvalid_o  out  1  fetch response valid.
- instr_rdata_o  out  32  fetch read data.
- instr_err_o  out  1  fetch bus error.
- data_req_i  in  1  LSU request.
- data_we_i  in  1  LSU write enable.
- data_be_i  in  4  LSU byte enables.
- data_addr_i  in  32  LSU address.
- data_wdata_i  in  32  LSU write data.
- data_gnt_o  out  1  LSU address phase accepted.
- data_rvalid_o  out  1  LSU response valid; also asserted for writes.
- data_rdata_o  out  32  LSU read data.
- data_err_o  out  1  LSU bus error.
- mem_req_o  out  1  memory request.
- mem_we_o  out  1  memory write enable.
- mem_be_o  out  4  memory byte enables.
- mem_addr_o  out  32  memory address.
- mem_wdata_o  out  32  memory write data.
- mem_gnt_i  in  1  memory grant.
- mem_rvalid_i  in  1  memory response valid.
- mem_rdata_i  in  32  memory read data.
- mem_err_i  in  1  memory error.
- protocol_err_o  out  1  sticky flag; set by an unexpected rvalid.

## Operation
- The FSM has two states: IDLE and LOCKED.
  - IDLE: the owner is chosen combinationally from the active requests (policy under Configuration).
  - If mem_req_o=1 and mem_gnt_i=0, the FSM goes to LOCKED and registers the owner.
  - LOCKED: the registered owner is forced; the other requester gets no grant.
  - The FSM returns to IDLE on the cycle mem_gnt_i=1.
- Address stability: once mem_req_o is asserted, its owner and payload do not change until granted.
- The requester must hold req and payload stable until its gnt.
- mem_req_o = owner_req & ~fifo_full. The mem_* payload muxes from the owner.
- For the instruction owner: mem_we_o=0 and mem_be_o=4'hF. mem_wdata_o follows data_wdata_i and is don't-care.
- gnt to the owner = mem_gnt_i & mem_req_o. The non-owner's gnt is 0.
- Owner FIFO:
  - MAX_OUTSTANDING entries, 1 bit each (0=instr, 1=data).
  - count is $clog2(MAX_OUTSTANDING+1) bits wide.
  - Push on grant, pop on mem_rvalid_i.
  - Push and pop in the same cycle: count is unchanged and the head advances.
- Response routing:
  - The head bit selects which side's rvalid gets mem_rvalid_i.
  - rdata and err go to both sides, qualified by the corresponding rvalid.
- mem_rvalid_i with count==0: dropped (no rvalid out, no pop), and protocol_err_o is set.
- protocol_err_o clears only on rst.
- fifo_full: mem_req_o is forced to 0. There is no same-cycle bypass of a pop, even when a pop occurs that cycle.

## Timing
- Request path is combinational: req_i → mem_req_o/mem_addr_o with zero cycles of latency.
- Grant path is combinational: mem_gnt_i → *_gnt_o.
- Response path is combinational: mem_rvalid_i → *_rvalid_o.
- Reset values:
  - FSM in IDLE, FIFO empty, count=0.
  - Round-robin pointer favours data.
  - protocol_err_o=0.
  - All outputs derived from the state above, so gnt/rvalid/mem_req_o are 0 whenever inputs are idle.
- Reset mid-operation: in-flight transactions are forgotten. Their later rvalids count as unexpected and set protocol_err_o.
- Back-to-back grants: one per cycle while not full.
- Maximum throughput: 1 transaction per cycle.

## Configuration
- ARB_ROUND_ROBIN_EN defined:
  - When both requests are active in IDLE, the requester not granted last wins.
  - The pointer updates on each grant.
- ARB_ROUND_ROBIN_EN undefined: fixed priority, data over instruction. The pointer register is not built.

## Test plan
- Single fetch, no contention.
  - Stimulus: instr_req_i=1, addr=0x100, mem_gnt_i=1 same cycle; rvalid 2 cycles later, rdata=0x00000013.
  - Expected: instr_gnt_o=1 in cycle 0; instr_rvalid_o=1 with rdata 0x00000013; data_rvalid_o=0.
- Contention.
  - Stimulus: both requests active, mem_gnt_i=1 every cycle.
  - Expected (fixed priority): data granted every cycle while data_req_i=1.
  - Expected (ARB_ROUND_ROBIN_EN): grants alternate data, instr, data, …
- Lock hold.
  - Stimulus: instr owns the port with mem_gnt_i=0 for 3 cycles; data_req_i rises in cycle 1.
  - Expected: mem_addr_o stays at the instr address; data_gnt_o=0 until the instr grant; data is granted the next cycle.
- Full FIFO, MAX_OUTSTANDING=2.
  - Stimulus: two grants with no rvalid.
  - Expected: mem_req_o=0 in the third cycle.
  - Stimulus: one rvalid.
  - Expected: mem_req_o reasserts the cycle after.
- Out-of-order owners.
  - Stimulus: grant data(read) then instr; then rvalids with rdata 0xA, then 0xB.
  - Expected: data_rvalid_o with 0xA, then instr_rvalid_o with 0xB.
- Spurious response.
  - Stimulus: mem_rvalid_i=1 with the FIFO empty.
  - Expected: no rvalid outputs; protocol_err_o=1 and held until rst.
